// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the DataMemory user-port arbiter.
//   state_e            : sequencer states (IDLE/ISSUE/WAIT/DONE)
//   GRANT_A / GRANT_B  : grant encoding (A = core data port, B = loader/debug port)
//   ERR_RDATA_DEFAULT  : read data returned by a timed-out read
//   TIMEOUT_DEFAULT    : default WAIT-cycle limit
//   word_addr()        : byte address -> word-aligned DataMemory address
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic GRANT_A = 1'b0;
  localparam logic GRANT_B = 1'b1;

  localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEADBEEF;
  localparam int unsigned TIMEOUT_DEFAULT   = 4096;

  function automatic logic [31:0] word_addr(input logic [31:0] byte_addr);
    return byte_addr & ~32'h3;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr.sv
// Two-way round-robin grant for the DataMemory arbiter.
//   clk, rst_x  : clock, synchronous active-low reset
//   req_a/req_b : request levels from port A / port B
//   take        : sequencer accepts the current grant this cycle
//   grant       : combinational choice for the current requests
//   last_grant  : registered winner of the most recent accepted grant
module dmem_rr_arbiter
  import dmem_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst_x,
  input  logic req_a,
  input  logic req_b,
  input  logic take,
  output logic grant,
  output logic last_grant
);

  logic last_grant_q;
  logic last_grant_d;

  // On a tie the port that did not win last time gets the slot.
  always_comb begin
    grant = last_grant_q;
    if (req_a && req_b) begin
      grant = ~last_grant_q;
    end else if (req_a) begin
      grant = GRANT_A;
    end else if (req_b) begin
      grant = GRANT_B;
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (take) begin
      last_grant_d = grant;
    end
  end

  // Reset to B so that A wins the first tie.
  always_ff @(posedge clk) begin
    if (!rst_x) begin
      last_grant_q <= GRANT_B;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

  assign last_grant = last_grant_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single DataMemory user port between the core data port (A)
// and a req/ack loader/debug port (B), with round-robin arbitration,
// a completion-timeout watchdog and a core stall-cycle counter.
//   CLK, RST_X            : clock, synchronous active-low reset
//   a_addr/a_oe/a_we/a_wdata -> a_rdata/a_stall : core data port
//   b_req/b_we/b_addr/b_wdata -> b_ack/b_rdata  : port B (ack pulses once)
//   mem_ren/mem_wen/mem_addr/mem_wdata <- mem_rdata/mem_stall : DataMemory
//   err       : sticky timeout flag
//   stall_cnt : saturating count of cycles with a_stall high
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
  parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEFAULT
) (
  input  logic        CLK,
  input  logic        RST_X,
  input  logic [31:0] a_addr,
  input  logic        a_oe,
  input  logic [3:0]  a_we,
  input  logic [31:0] a_wdata,
  output logic [31:0] a_rdata,
  output logic        a_stall,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [31:0] b_addr,
  input  logic [31:0] b_wdata,
  output logic        b_ack,
  output logic [31:0] b_rdata,
  output logic        mem_ren,
  output logic [3:0]  mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_stall,
  output logic        err,
  output logic [31:0] stall_cnt
);

  localparam int unsigned TCNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);

  state_e state_q, state_d;

  logic              cmd_ren_q,   cmd_ren_d;
  logic [3:0]        cmd_wen_q,   cmd_wen_d;
  logic [31:0]       cmd_addr_q,  cmd_addr_d;
  logic [31:0]       cmd_wdata_q, cmd_wdata_d;
  logic              seen_busy_q, seen_busy_d;
  logic [TCNT_W-1:0] tcnt_q,      tcnt_d;
  logic [31:0]       a_rdata_q,   a_rdata_d;
  logic [31:0]       b_rdata_q,   b_rdata_d;
  logic              err_q,       err_d;
  logic [31:0]       stall_cnt_q, stall_cnt_d;

  logic a_req;
  logic take;
  logic grant;
  logic cur_grant;
  logic normal_exit;
  logic timeout_hit;

  assign a_req = a_oe | (|a_we);
  assign take  = (state_q == S_IDLE) && (a_req || b_req);

  dmem_rr_arbiter u_rr (
    .clk        (CLK),
    .rst_x      (RST_X),
    .req_a      (a_req),
    .req_b      (b_req),
    .take       (take),
    .grant      (grant),
    .last_grant (cur_grant)
  );

  // Completion needs a busy cycle first: a low mem_stall right after issue
  // only means the memory has not picked the command up yet.
  assign normal_exit = (state_q == S_WAIT) && !mem_stall && seen_busy_q;
  assign timeout_hit = (state_q == S_WAIT) && !normal_exit && (tcnt_q == TCNT_LAST);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge CLK) begin
    if (!RST_X) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (take) state_d = S_ISSUE;
      S_ISSUE: if (!mem_stall) state_d = S_WAIT;
      S_WAIT:  if (normal_exit || timeout_hit) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    mem_ren = 1'b0;
    mem_wen = '0;
    b_ack   = 1'b0;
    a_stall = a_req;
    case (state_q)
      S_ISSUE: begin
        if (!mem_stall) begin
          mem_ren = cmd_ren_q;
          mem_wen = cmd_wen_q;
        end
      end
      S_DONE: begin
        if (cur_grant == GRANT_B) begin
          b_ack = 1'b1;
        end else begin
          a_stall = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // ---------------- datapath next-state ----------------
  always_comb begin
    cmd_ren_d   = cmd_ren_q;
    cmd_wen_d   = cmd_wen_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    seen_busy_d = seen_busy_q;
    tcnt_d      = tcnt_q;
    a_rdata_d   = a_rdata_q;
    b_rdata_d   = b_rdata_q;
    err_d       = err_q;

    case (state_q)
      S_IDLE: begin
        if (take) begin
          if (grant == GRANT_A) begin
            cmd_ren_d   = a_oe;
            cmd_wen_d   = a_we;
            cmd_addr_d  = word_addr(a_addr);
            cmd_wdata_d = a_wdata;
          end else begin
            cmd_ren_d   = ~b_we;
            cmd_wen_d   = {4{b_we}};
            cmd_addr_d  = word_addr(b_addr);
            cmd_wdata_d = b_wdata;
          end
        end
      end
      S_ISSUE: begin
        if (!mem_stall) begin
          seen_busy_d = 1'b0;
          tcnt_d      = '0;
        end
      end
      S_WAIT: begin
        if (mem_stall) begin
          seen_busy_d = 1'b1;
        end
        if (normal_exit) begin
          if (cmd_ren_q) begin
            if (cur_grant == GRANT_A) a_rdata_d = mem_rdata;
            else                      b_rdata_d = mem_rdata;
          end
        end else if (timeout_hit) begin
          err_d = 1'b1;
          if (cmd_ren_q) begin
            if (cur_grant == GRANT_A) a_rdata_d = ERR_RDATA;
            else                      b_rdata_d = ERR_RDATA;
          end
        end else begin
          tcnt_d = tcnt_q + TCNT_W'(1);
        end
      end
      default: ;
    endcase

    stall_cnt_d = stall_cnt_q;
    if (a_stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_X) begin
      cmd_ren_q   <= 1'b0;
      cmd_wen_q   <= '0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      seen_busy_q <= 1'b0;
      tcnt_q      <= '0;
      a_rdata_q   <= '0;
      b_rdata_q   <= '0;
      err_q       <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      cmd_ren_q   <= cmd_ren_d;
      cmd_wen_q   <= cmd_wen_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      seen_busy_q <= seen_busy_d;
      tcnt_q      <= tcnt_d;
      a_rdata_q   <= a_rdata_d;
      b_rdata_q   <= b_rdata_d;
      err_q       <= err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign mem_addr  = cmd_addr_q;
  assign mem_wdata = cmd_wdata_q;
  assign a_rdata   = a_rdata_q;
  assign b_rdata   = b_rdata_q;
  assign err       = err_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Sequences and shares the single DataMemory user port (ren/wen/addr/data/stall) between two requesters.
- Port A is the processor core data port (D_ADDR/D_OE/D_WE/D_OUT/D_IN/STALL).
- Port B is a req/ack port for a word-wide loader or debug agent, for example a UART data-memory loader.
- Also provides round-robin arbitration, a completion-timeout watchdog and a core stall-cycle counter readable by the VIO.

Parameters:
- TIMEOUT_CYCLES, 4096: maximum WAIT cycles before a transaction is force-completed with error.
- ERR_RDATA, 32'hDEADBEEF: read data returned on a timed-out read.

Ports:
- CLK  in  1  system clock (user clock from DataMemory).
- RST_X  in  1  reset; synchronous, active-low.
- a_addr  in  32  core byte address.
- a_oe  in  1  core read request.
- a_we  in  4  core byte-write enables.
- a_wdata  in  32  core write data.
- a_rdata  out  32  core read data.
- a_stall  out  1  core stall.
- b_req  in  1  port-B request (level).
- b_we  in  1  port-B write (1) / read (0).
- b_addr  in  32  port-B byte address.
- b_wdata  in  32  port-B write data.
- b_ack  out  1  port-B completion pulse.
- b_rdata  out  32  port-B read data.
- mem_ren  out  1  DataMemory read command.
- mem_wen  out  4  DataMemory byte-write command.
- mem_addr  out  32  DataMemory address, always {addr[31:2],2'b00}.
- mem_wdata  out  32  DataMemory write data.
- mem_rdata  in  32  DataMemory read data.
- mem_stall  in  1  DataMemory busy.
- err  out  1  sticky timeout flag.
- stall_cnt  out  32  core stall-cycle counter.

Behaviour:
- Reset (RST_X=0 at a CLK edge) forces the following, regardless of state, even mid-transaction:
  - state=IDLE, last_grant=B (so A wins first tie).
  - mem_ren=0, mem_wen=0, mem_addr=0, mem_wdata=0.
  - a_rdata=0, b_rdata=0, b_ack=0, err=0, stall_cnt=0, timeout counter=0.
- a_stall is not forced to 0 by reset; it follows its combinational definition.
- A request is "a_oe | (|a_we)" on port A, and "b_req" on port B.
- Requesters hold their request, address and data stable until completion: A until a_stall is low, B until b_ack.
- FSM states are IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If only one port requests, grant it.
  - If both request, grant the port other than last_grant (round-robin).
  - Latch op, address and wdata into command registers; set last_grant; go to ISSUE.
  - With no request, stay in IDLE.
  - Port B op: read → ren=1; write → wen=4'hF.
- ISSUE:
  - While mem_stall=1, hold with mem_ren/mem_wen=0. This covers a DRAM still busy after a reset.
  - When mem_stall=0, drive the command for exactly one cycle, clear seen_busy and the timeout counter, and go to WAIT.
- WAIT:
  - Set seen_busy whenever mem_stall=1.
  - Exit when mem_stall=0 and seen_busy=1. On exit, register mem_rdata into the granted port's rdata; for writes, rdata is unchanged.
  - The timeout counter increments each WAIT cycle. On reaching TIMEOUT_CYCLES-1 without normal exit, set err, load ERR_RDATA for reads, and exit.
  - Both exits go to DONE.
- DONE (1 cycle):
  - If the grant is B, b_ack=1 for this cycle only.
  - Then go to IDLE.
- a_stall (combinational) = A-request & !(state==DONE & grant==A).
  - The core therefore sees a_stall low in exactly one cycle per access, with a_rdata valid in that cycle.
- Minimum latency from request seen in IDLE to DONE is 4 cycles (IDLE, ISSUE, WAIT ≥1 busy cycle + 1 idle cycle, DONE).
- The back-to-back issue gap is 1 cycle (DONE→IDLE).
- A port-B read never alters a_rdata; a port-A access never pulses b_ack.
- stall_cnt increments every cycle a_stall=1 and saturates at 32'hFFFFFFFF.
- err clears only on reset.
- An A request dropped mid-transaction (illegal) does not abort the transaction; the FSM completes it.

Decomposition:
- Shared package holds:
  - State encoding localparams S_IDLE=2'd0, S_ISSUE=2'd1, S_WAIT=2'd2, S_DONE=2'd3.
  - GRANT_A=1'b0, GRANT_B=1'b1.
  - Default ERR_RDATA.
- One natural sub-module: dmem_rr_arbiter, a 2-way round-robin grant with last_grant register.

Test Plan:
- Core read of 0x104 (mem_rdata=0x12345678, mem_stall high 5 cycles) → mem_addr=0x104, mem_ren pulse width 1; a_stall low for exactly 1 cycle; a_rdata=0x12345678.
- Core write a_we=4'b0011 to 0x0A with a_wdata=0xCAFEBABE → mem_wen=4'b0011, mem_addr=0x08, mem_wdata=0xCAFEBABE.
- A and B request simultaneously from reset for 3 accesses each → grant order A,B,A,B,A,B; b_ack count=3.
- mem_stall stuck at 0 after an A read with TIMEOUT_CYCLES=16 → completion after 16 WAIT cycles; err=1; a_rdata=0xDEADBEEF.
- mem_stall=1 entering ISSUE for 10 cycles → no mem_ren until mem_stall drops; stall_cnt reflects all A stall cycles.
- RST_X=0 for one cycle during WAIT → next cycle state=IDLE, mem_ren/mem_wen=0, err=0, stall_cnt=0; a held A request is re-issued correctly.
